// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, instruction
// classes, MIPS opcode/funct codes, the shared ALU op encoding and pc_src codes.
package cu_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned PC_SRC_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MULDIV_WAIT,
    ST_MEM,
    ST_WB,
    ST_HALT
  } cu_state_e;

  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_MULDIV,
    CLS_IALU,
    CLS_BRANCH,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_LOAD,
    CLS_STORE,
    CLS_SYSCALL
  } instr_cls_e;

  // Decoder result handed from cu_decode to the FSM
  typedef struct packed {
    instr_cls_e cls;
    logic       byte_acc;
    logic       legal;
  } dec_info_t;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_R     = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_BLEZ  = 6'h06;
  localparam logic [OPC_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LB    = 6'h20;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SB    = 6'h28;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // Special funct codes
  localparam logic [OPC_W-1:0] FN_JR      = 6'h08;
  localparam logic [OPC_W-1:0] FN_SYSCALL = 6'h0C;
  localparam logic [OPC_W-1:0] FN_MULT    = 6'h18;
  localparam logic [OPC_W-1:0] FN_DIV     = 6'h1A;

  // Shared ALU op encoding: R-type ops reuse their funct value
  localparam logic [OPC_W-1:0] ALU_SLL  = 6'h00;
  localparam logic [OPC_W-1:0] ALU_SRL  = 6'h02;
  localparam logic [OPC_W-1:0] ALU_SRA  = 6'h03;
  localparam logic [OPC_W-1:0] ALU_SLLV = 6'h04;
  localparam logic [OPC_W-1:0] ALU_SRLV = 6'h06;
  localparam logic [OPC_W-1:0] ALU_MULT = 6'h18;
  localparam logic [OPC_W-1:0] ALU_DIV  = 6'h1A;
  localparam logic [OPC_W-1:0] ALU_ADD  = 6'h20;
  localparam logic [OPC_W-1:0] ALU_ADDU = 6'h21;
  localparam logic [OPC_W-1:0] ALU_SUB  = 6'h22;
  localparam logic [OPC_W-1:0] ALU_SUBU = 6'h23;
  localparam logic [OPC_W-1:0] ALU_AND  = 6'h24;
  localparam logic [OPC_W-1:0] ALU_OR   = 6'h25;
  localparam logic [OPC_W-1:0] ALU_XOR  = 6'h26;
  localparam logic [OPC_W-1:0] ALU_NOR  = 6'h27;
  localparam logic [OPC_W-1:0] ALU_SLT  = 6'h2A;
  // Compare ops: result is 0 when the branch condition holds
  localparam logic [OPC_W-1:0] ALU_CMP_EQ  = 6'h30;
  localparam logic [OPC_W-1:0] ALU_CMP_NE  = 6'h31;
  localparam logic [OPC_W-1:0] ALU_CMP_LEZ = 6'h32;
  localparam logic [OPC_W-1:0] ALU_CMP_GTZ = 6'h33;

  // Next-PC source select
  localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [PC_SRC_W-1:0] PC_SRC_RS     = 2'd3;

endpackage

// File: rtl/multicycle_cu_if.sv
// Memory and ALU handshake bundle between the control unit and the datapath.
//   master: control unit (drives requests/strobes, samples readys/flags)
//   slave : memories + ALU
interface multicycle_cu_if #(
  parameter int unsigned ALU_OP_W = 6
) ();
  logic                imem_req;
  logic                imem_ready;
  logic [31:0]         imem_rdata;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_byte;
  logic                dmem_ready;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                alu_start;
  logic                alu_done;
  logic                zero;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_byte, alu_op, alu_src, alu_start,
    input  imem_ready, imem_rdata, dmem_ready, alu_done, zero
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_byte, alu_op, alu_src, alu_start,
    output imem_ready, imem_rdata, dmem_ready, alu_done, zero
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational instruction classifier.
//   opcode_i/funct_i : ir[31:26] / ir[5:0]
//   info_o           : instruction class, byte-access flag, legal flag
//   alu_op_o         : ALU operation used in EXEC
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 6
) (
  input  logic [OPC_W-1:0]    opcode_i,
  input  logic [OPC_W-1:0]    funct_i,
  output dec_info_t           info_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  always_comb begin
    info_o.cls      = CLS_RALU;
    info_o.byte_acc = 1'b0;
    info_o.legal    = 1'b1;
    alu_op_o        = '0;
    case (opcode_i)
      OP_R: begin
        if (funct_i inside {ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
                            ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA,
                            ALU_SLLV, ALU_SRLV}) begin
          info_o.cls = CLS_RALU;
          alu_op_o   = ALU_OP_W'(funct_i);
        end else if (funct_i == FN_MULT || funct_i == FN_DIV) begin
          info_o.cls = CLS_MULDIV;
          alu_op_o   = ALU_OP_W'(funct_i);
        end else if (funct_i == FN_JR) begin
          info_o.cls = CLS_JR;
        end else if (funct_i == FN_SYSCALL) begin
          info_o.cls = CLS_SYSCALL;
        end else begin
          info_o.legal = 1'b0;
        end
      end
      OP_J:     info_o.cls = CLS_J;
      OP_JAL:   info_o.cls = CLS_JAL;
      OP_BEQ:   begin info_o.cls = CLS_BRANCH; alu_op_o = ALU_OP_W'(ALU_CMP_EQ);  end
      OP_BNE:   begin info_o.cls = CLS_BRANCH; alu_op_o = ALU_OP_W'(ALU_CMP_NE);  end
      OP_BLEZ:  begin info_o.cls = CLS_BRANCH; alu_op_o = ALU_OP_W'(ALU_CMP_LEZ); end
      OP_BGTZ:  begin info_o.cls = CLS_BRANCH; alu_op_o = ALU_OP_W'(ALU_CMP_GTZ); end
      OP_ADDI:  begin info_o.cls = CLS_IALU;   alu_op_o = ALU_OP_W'(ALU_ADD);     end
      OP_ADDIU: begin info_o.cls = CLS_IALU;   alu_op_o = ALU_OP_W'(ALU_ADDU);    end
      OP_ANDI:  begin info_o.cls = CLS_IALU;   alu_op_o = ALU_OP_W'(ALU_AND);     end
      OP_ORI:   begin info_o.cls = CLS_IALU;   alu_op_o = ALU_OP_W'(ALU_OR);      end
      OP_XORI:  begin info_o.cls = CLS_IALU;   alu_op_o = ALU_OP_W'(ALU_XOR);     end
      OP_LW:    begin info_o.cls = CLS_LOAD;   alu_op_o = ALU_OP_W'(ALU_ADD);     end
      OP_SW:    begin info_o.cls = CLS_STORE;  alu_op_o = ALU_OP_W'(ALU_ADD);     end
      OP_LB: begin
        info_o.cls      = CLS_LOAD;
        info_o.byte_acc = 1'b1;
        alu_op_o        = ALU_OP_W'(ALU_ADD);
      end
      OP_SB: begin
        info_o.cls      = CLS_STORE;
        info_o.byte_acc = 1'b1;
        alu_op_o        = ALU_OP_W'(ALU_ADD);
      end
      default:  info_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MULDIV_WAIT/MEM/WB
// per instruction and stops in HALT on SYSCALL or a trap.
//   clk, rst_b         : clock, async active-low reset
//   bus (master)       : imem/dmem handshakes, ALU op/start/done, zero flag
//   ir                 : latched instruction register
//   reg_write..pc_src  : datapath mux selects and write enables
//   halted, illegal    : sticky stop status (illegal = stopped by a trap)
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 6,
  parameter int unsigned MULDIV_MAX = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  multicycle_cu_if.master     bus,
  output logic [31:0]         ir,
  output logic                reg_write,
  output logic                reg_dest,
  output logic                link,
  output logic                mem_to_reg,
  output logic                pc_write,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                halted,
  output logic                illegal
);

  localparam int unsigned CNT_W = $clog2(MULDIV_MAX + 1);

  cu_state_e           state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                illegal_q, illegal_d;

  dec_info_t           dec;
  logic [ALU_OP_W-1:0] dec_alu_op;

  logic                imem_req_c, dmem_req_c, dmem_we_c, dmem_byte_c;
  logic                alu_src_c, alu_start_c;
  logic [ALU_OP_W-1:0] alu_op_c;

  cu_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
    .opcode_i (ir_q[31:26]),
    .funct_i  (ir_q[5:0]),
    .info_o   (dec),
    .alu_op_o (dec_alu_op)
  );

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; the wait counter clears whenever it is not counting
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!dec.legal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (dec.cls == CLS_SYSCALL) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec.cls)
          CLS_RALU, CLS_IALU:  state_d = ST_WB;
          CLS_MULDIV:          state_d = ST_MULDIV_WAIT;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MULDIV_WAIT: begin
        // done wins over timeout when both land in the same cycle
        if (bus.alu_done) begin
          state_d = ST_WB;
        end else if (cnt_q == CNT_W'(MULDIV_MAX)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MEM: begin
        if (bus.dmem_ready) begin
          state_d = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Moore outputs; all forced low while reset is asserted
  always_comb begin
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    dmem_byte_c = 1'b0;
    alu_op_c    = '0;
    alu_src_c   = 1'b0;
    alu_start_c = 1'b0;
    reg_write   = 1'b0;
    reg_dest    = 1'b0;
    link        = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    halted      = 1'b0;
    if (rst_b) begin
      case (state_q)
        ST_FETCH: begin
          imem_req_c = 1'b1;
          pc_write   = bus.imem_ready;
        end
        ST_EXEC: begin
          alu_op_c = dec_alu_op;
          case (dec.cls)
            CLS_IALU, CLS_LOAD, CLS_STORE: alu_src_c = 1'b1;
            CLS_MULDIV: alu_start_c = 1'b1;
            CLS_BRANCH: begin
              pc_write = bus.zero;
              pc_src   = PC_SRC_BRANCH;
            end
            CLS_J: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
            CLS_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              link      = 1'b1;
            end
            CLS_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_RS;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req_c  = 1'b1;
          dmem_we_c   = (dec.cls == CLS_STORE);
          dmem_byte_c = dec.byte_acc;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dest   = (dec.cls == CLS_RALU) || (dec.cls == CLS_MULDIV);
          mem_to_reg = (dec.cls == CLS_LOAD);
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_c;
  assign bus.dmem_req  = dmem_req_c;
  assign bus.dmem_we   = dmem_we_c;
  assign bus.dmem_byte = dmem_byte_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.alu_src   = alu_src_c;
  assign bus.alu_start = alu_start_c;
  assign ir            = ir_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: instruction sequences with hand-computed
// cycle-by-cycle expectations on the control outputs.
module tb_multicycle_cu;

  localparam logic [31:0] I_ADD     = 32'h012A4020;
  localparam logic [31:0] I_BEQ     = 32'h11090003;
  localparam logic [31:0] I_LB      = 32'h81090004;
  localparam logic [31:0] I_SW      = 32'hAD090004;
  localparam logic [31:0] I_JAL     = 32'h0C000010;
  localparam logic [31:0] I_JR      = 32'h03E00008;
  localparam logic [31:0] I_DIV     = 32'h0109001A;
  localparam logic [31:0] I_SYSCALL = 32'h0000000C;
  localparam logic [31:0] I_BADOP   = 32'hFC000000;

  logic        clk;
  logic        rst_b;
  logic [31:0] ir;
  logic        reg_write, reg_dest, link, mem_to_reg, pc_write, halted, illegal;
  logic [1:0]  pc_src;
  int          n_tests;
  int          n_fail;

  multicycle_cu_if #(.ALU_OP_W(6)) bus ();

  multicycle_cu #(.ALU_OP_W(6), .MULDIV_MAX(64)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bus        (bus),
    .ir         (ir),
    .reg_write  (reg_write),
    .reg_dest   (reg_dest),
    .link       (link),
    .mem_to_reg (mem_to_reg),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Reset with immediate check that requests drop, then release into FETCH
  task automatic apply_reset(input string tag);
    rst_b = 1'b0;
    #1;
    check({tag, "_rst_imem_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_rst_dmem_req"}, 32'(bus.dmem_req), 32'd0);
    step();
    rst_b = 1'b1;
    #1;
    check({tag, "_rst_ir"}, ir, 32'd0);
    check({tag, "_rst_halted"}, 32'(halted), 32'd0);
    check({tag, "_rst_illegal"}, 32'(illegal), 32'd0);
    check({tag, "_rst_fetch_req"}, 32'(bus.imem_req), 32'd1);
  endtask

  // Called in a FETCH cycle; returns in the DECODE cycle
  task automatic fetch(input string tag, input logic [31:0] instr);
    bus.imem_rdata = instr;
    bus.imem_ready = 1'b1;
    #1;
    check({tag, "_f_imem_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, "_f_pc_write"}, 32'(pc_write), 32'd1);
    check({tag, "_f_pc_src"}, 32'(pc_src), 32'd0);
    step();
    bus.imem_ready = 1'b0;
    #1;
    check({tag, "_d_ir"}, ir, instr);
    check({tag, "_d_imem_req"}, 32'(bus.imem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0;
    bus.alu_done   = 1'b0;
    bus.zero       = 1'b0;
    apply_reset("init");

    // ADD with imem_ready held high throughout
    bus.imem_rdata = I_ADD;
    bus.imem_ready = 1'b1;
    #1;
    check("add_c0_imem_req", 32'(bus.imem_req), 32'd1);
    check("add_c0_pc_write", 32'(pc_write), 32'd1);
    step(); #1;
    check("add_c1_imem_req", 32'(bus.imem_req), 32'd0);
    check("add_c1_pc_write", 32'(pc_write), 32'd0);
    step(); #1;
    check("add_c2_alu_op", 32'(bus.alu_op), 32'h20);
    check("add_c2_reg_write", 32'(reg_write), 32'd0);
    check("add_c2_pc_write", 32'(pc_write), 32'd0);
    step(); #1;
    check("add_c3_reg_write", 32'(reg_write), 32'd1);
    check("add_c3_reg_dest", 32'(reg_dest), 32'd1);
    check("add_c3_ir_held", ir, I_ADD);
    step(); #1;
    check("add_c4_imem_req", 32'(bus.imem_req), 32'd1);

    // BEQ taken
    fetch("beq1", I_BEQ);
    step();
    bus.zero = 1'b1;
    #1;
    check("beq1_pc_write", 32'(pc_write), 32'd1);
    check("beq1_pc_src", 32'(pc_src), 32'd1);
    check("beq1_alu_op", 32'(bus.alu_op), 32'h30);
    step();
    bus.zero = 1'b0;

    // BEQ not taken
    fetch("beq0", I_BEQ);
    step(); #1;
    check("beq0_pc_write", 32'(pc_write), 32'd0);
    step(); #1;

    // FETCH holds while imem_ready is low
    check("hold_pc_write", 32'(pc_write), 32'd0);
    step(); #1;
    check("hold_imem_req", 32'(bus.imem_req), 32'd1);
    check("hold_ir", ir, I_BEQ);

    // LB with dmem_ready in the fourth MEM cycle
    fetch("lb", I_LB);
    step(); #1;
    check("lb_alu_src", 32'(bus.alu_src), 32'd1);
    check("lb_alu_op", 32'(bus.alu_op), 32'h20);
    check("lb_exec_dmem_req", 32'(bus.dmem_req), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      #1;
      check("lb_dmem_req", 32'(bus.dmem_req), 32'd1);
      check("lb_dmem_byte", 32'(bus.dmem_byte), 32'd1);
      check("lb_dmem_we", 32'(bus.dmem_we), 32'd0);
      step();
    end
    bus.dmem_ready = 1'b0;
    #1;
    check("lb_wb_reg_write", 32'(reg_write), 32'd1);
    check("lb_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lb_wb_reg_dest", 32'(reg_dest), 32'd0);
    step();

    // JAL
    fetch("jal", I_JAL);
    step(); #1;
    check("jal_pc_write", 32'(pc_write), 32'd1);
    check("jal_pc_src", 32'(pc_src), 32'd2);
    check("jal_reg_write", 32'(reg_write), 32'd1);
    check("jal_link", 32'(link), 32'd1);
    step();

    // JR
    fetch("jr", I_JR);
    step(); #1;
    check("jr_pc_write", 32'(pc_write), 32'd1);
    check("jr_pc_src", 32'(pc_src), 32'd3);
    step();

    // DIV with alu_done in the 10th wait cycle
    fetch("div10", I_DIV);
    step(); #1;
    check("div10_alu_start", 32'(bus.alu_start), 32'd1);
    check("div10_alu_op", 32'(bus.alu_op), 32'h1A);
    step();
    for (int i = 0; i < 10; i++) begin
      bus.alu_done = (i == 9);
      #1;
      if (i == 0) check("div10_wait_start", 32'(bus.alu_start), 32'd0);
      check("div10_wait_reg_write", 32'(reg_write), 32'd0);
      step();
    end
    bus.alu_done = 1'b0;
    #1;
    check("div10_wb_reg_write", 32'(reg_write), 32'd1);
    check("div10_wb_reg_dest", 32'(reg_dest), 32'd1);
    step();

    // DIV with alu_done exactly when the counter reaches MULDIV_MAX
    fetch("divmax", I_DIV);
    step(); step();
    for (int i = 0; i <= 64; i++) begin
      bus.alu_done = (i == 64);
      #1;
      if (i == 64) check("divmax_halted_before", 32'(halted), 32'd0);
      step();
    end
    bus.alu_done = 1'b0;
    #1;
    check("divmax_wb_reg_write", 32'(reg_write), 32'd1);
    check("divmax_illegal", 32'(illegal), 32'd0);
    step();

    // SW interrupted by reset while waiting in MEM
    fetch("sw", I_SW);
    step(); step(); #1;
    check("sw_dmem_req", 32'(bus.dmem_req), 32'd1);
    check("sw_dmem_we", 32'(bus.dmem_we), 32'd1);
    check("sw_dmem_byte", 32'(bus.dmem_byte), 32'd0);
    apply_reset("sw");

    // DIV that never completes traps
    fetch("divto", I_DIV);
    step(); step();
    for (int i = 0; i <= 64; i++) begin
      #1;
      if (i == 64) check("divto_halted_before", 32'(halted), 32'd0);
      step();
    end
    #1;
    check("divto_halted", 32'(halted), 32'd1);
    check("divto_illegal", 32'(illegal), 32'd1);
    bus.imem_ready = 1'b1;
    repeat (3) step();
    #1;
    check("divto_no_imem_req", 32'(bus.imem_req), 32'd0);
    check("divto_still_halted", 32'(halted), 32'd1);
    bus.imem_ready = 1'b0;
    apply_reset("divto");

    // SYSCALL halts without trap
    fetch("sys", I_SYSCALL);
    step(); #1;
    check("sys_halted", 32'(halted), 32'd1);
    check("sys_illegal", 32'(illegal), 32'd0);
    bus.imem_ready = 1'b1;
    repeat (2) step();
    #1;
    check("sys_no_imem_req", 32'(bus.imem_req), 32'd0);
    bus.imem_ready = 1'b0;
    apply_reset("sys");

    // Unknown opcode traps
    fetch("bad", I_BADOP);
    step(); #1;
    check("bad_illegal", 32'(illegal), 32'd1);
    check("bad_halted", 32'(halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle successor to the combinational MIPS control unit: a state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives handshaked instruction and data memory ports and a variable-latency ALU for MULT/DIV. It adds LB/SB byte accesses, SYSCALL halt and illegal-instruction trapping. It sits between the instruction register and the datapath muxes of the multi-cycle core.

## Interface
Parameters:
- ALU_OP_W, 6, width of `alu_op`; must match the shared ALU op encoding.
- MULDIV_MAX, 64, maximum cycles to wait for `alu_done` before trapping.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  latched instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_byte  out  1  byte access (LB/SB) when 1, word access when 0.
- dmem_ready  in  1  data access complete.
- alu_op  out  ALU_OP_W  ALU operation.
- alu_src  out  1  selects the immediate as ALU operand B.
- alu_start  out  1  one-cycle start pulse for MULT/DIV.
- alu_done  in  1  MULT/DIV result valid.
- zero  in  1  ALU zero flag.
- reg_write, reg_dest, link, mem_to_reg  out  1 each  register-file write enable, rd/rt select, $31/PC+4 select, memory-data select.
- pc_write  out  1  PC update enable.
- pc_src  out  2  next-PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- halted  out  1  core stopped (sticky).
- illegal  out  1  stopped by a trap (sticky).

## Operation
- **States:** FETCH, DECODE, EXEC, MULDIV_WAIT, MEM, WB, HALT.
- **FETCH:**
  - `imem_req` = 1.
  - On `imem_ready`: `ir` ← `imem_rdata`, `pc_write` = 1, `pc_src` = 0, go to DECODE.
  - Otherwise hold in FETCH.
- **DECODE:** classifies `ir[31:26]`/`ir[5:0]`.
  - SYSCALL → HALT.
  - Unknown opcode or funct → HALT with `illegal` set.
  - All others → EXEC.
- **EXEC:**
  - **R-type ALU ops** (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, SLLV, SRLV): drive `alu_op` → WB.
  - **MULT/DIV:** `alu_start` = 1 → MULDIV_WAIT.
  - **I-type ALU ops** (ADDI, ADDIU, ANDI, ORI, XORI): `alu_src` = 1 → WB.
  - **Branches** (BEQ, BNE, BLEZ, BGTZ): compare ops keep the existing convention that an ALU result of 0 means taken. `pc_write` = `zero`, `pc_src` = 1 → FETCH.
  - **J:** `pc_write`, `pc_src` = 2 → FETCH.
  - **JAL:** as J, plus `reg_write` and `link` → FETCH.
  - **JR:** `pc_write`, `pc_src` = 3 → FETCH.
  - **LW/LB/SW/SB:** `alu_src` = 1, `alu_op` = ADD → MEM.
- **MULDIV_WAIT:**
  - A counter runs from 0; on `alu_done` → WB.
  - If the counter reaches MULDIV_MAX → HALT with `illegal` set.
- **MEM:**
  - `dmem_req` = 1; `dmem_we` = 1 for stores; `dmem_byte` = 1 for LB/SB.
  - Hold until `dmem_ready`, then loads → WB and stores → FETCH.
- **WB:**
  - `reg_write` = 1.
  - `reg_dest` = 1 for R-type; `mem_to_reg` = 1 for loads → FETCH.
- **HALT:** absorbing; all request and strobe outputs are 0; `halted` = 1.
- Outputs are Moore functions of state plus `ir` (and `zero` in EXEC). Any output not listed for a state is 0.

## Timing
- **Reset value:**
  - State FETCH; `ir` = 0; MULDIV counter = 0.
  - `halted` = `illegal` = 0; all strobes 0; `alu_op` = 0; `pc_src` = 0.
- **Reset mid-operation:** state is forced to FETCH immediately (asynchronously); `imem_req` and `dmem_req` drop in the same cycle.
- **Minimum latency** with zero-wait memory:
  - Branch, jump and JR: 3 cycles.
  - ALU ops: 4 cycles.
  - Stores: 4 cycles.
  - Loads: 5 cycles.
  - MULT/DIV: 4 cycles plus the `alu_done` delay.
- **Handshakes:**
  - A ready sampled in the same cycle as its request completes the transfer.
  - A ready while the request is low is ignored.
  - The request stays high until ready.
- **MULDIV_WAIT boundary:** `alu_done` arriving in the cycle the counter hits MULDIV_MAX counts as success.

## Structure
- Shared package `cu_pkg`:
  - State enum.
  - Opcode and funct localparams: R=0x00, J=0x02, JAL=0x03, BEQ=0x04, BNE=0x05, BLEZ=0x06, BGTZ=0x07, ADDI=0x08, ADDIU=0x09, ANDI=0x0C, ORI=0x0D, XORI=0x0E, LB=0x20, LW=0x23, SB=0x28, SW=0x2B; funct SYSCALL=0x0C, JR=0x08, MULT=0x18, DIV=0x1A.
  - `pc_src` encodings.
- ALU op codes come from the existing ALU op definitions; they are not duplicated.
- One combinational sub-module, `cu_decode`: `ir` → instruction class, `alu_op`, and a legal flag. The FSM itself stays in `multicycle_cu`.

## Test plan
- **ADD** (0x012A4020), `imem_ready` held high: `imem_req` rises in cycle 0, `pc_write` pulses once in FETCH, `reg_write` = 1 with `reg_dest` = 1 in cycle 3, back in FETCH at cycle 4.
- **BEQ** with `zero` = 1, then `zero` = 0: `pc_write` = 1 with `pc_src` = 1 in EXEC for the first; no EXEC `pc_write` for the second. 3 cycles each.
- **LB** with `dmem_ready` delayed 3 cycles: `dmem_req` = 1 and `dmem_byte` = 1 for 4 cycles, then WB with `mem_to_reg` = 1.
- **DIV** with `alu_done` after 10 cycles → WB; `alu_done` never asserted → `illegal` = `halted` = 1 after MULDIV_MAX cycles.
- **SYSCALL** → `halted` = 1, `illegal` = 0, no further `imem_req`. Opcode 0x3F → `illegal` = 1.
- **Reset mid-MEM:** `rst_b` low during a pending SW → `dmem_req` = 0 immediately; after release, FETCH with `ir` = 0.
